nbiot_channel_interleaver: RTL and testbench
============================================

Name: nbiot_channel_interleaver

Overview:
- Row-column channel interleaver for the NB-IoT NPUSCH uplink chain; sits after rate matching / code-block concatenation and before the scrambler/modulator.
- Captures a parallel block of K+4 coded bits, writes them row-wise into a virtual matrix of C = 6*n_slots columns, and streams them out column-wise, one bit per clock.
- Null (pad) positions are skipped, so exactly K+4 bits are output per block.

Parameters:
- K, 2560, payload size; the input block is K+4 bits (K plus 4 tail bits).
- SYM_PER_SLOT, 6, data SC-FDMA symbols per slot (7 minus 1 DMRS); C = SYM_PER_SLOT*n_slots.

Ports:
- clk  input  1  system clock; all state on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- n_slots  input  5  number of slots; sampled at block start.
- in_en  input  1  start request; level-sensitive, sampled only in IDLE.
- a  input  K+4  coded block, declared [0:K+3]; a[0] (MSB, leftmost) is bit 0.
- y  output  1  interleaved serial bit, registered.
- out_en  output  1  high while y carries a valid bit.

Behaviour:
- Reset (reset=0, async): state=IDLE, y=0, out_en=0, all counters and latches 0.
- Capture: in IDLE, if in_en=1 at a rising edge, latch a into an internal K+4 register and compute C = 6*max(n_slots,1), so n_slots=0 is treated as 1. Go to SETUP. Input changes after capture do not affect the block in flight.
- SETUP: iterative division with no divider.
  - Initial values: rem=K+4, R=0.
  - Each cycle: R<=R+1. If rem>C then rem<=rem-C; else L<=rem and go to OUTPUT.
  - Result: R = ceil((K+4)/C) rows. L (1..C) = occupied columns of the last row. Cost: R cycles.
- OUTPUT: column-major read, one bit per cycle.
  - Column c holds R bits if c<L, else R-1 bits.
  - Index idx starts at c for each column and increments by C per row (adder only, no multiplier).
  - Registered output: y<=a_reg[idx], out_en<=1.
  - Exactly K+4 consecutive out_en=1 cycles, with no gaps.
  - After the last bit of column C-1, go to DONE.
- DONE: one cycle with out_en=0, y=0, then back to IDLE. If in_en is still high, the next block starts (continuous in_en gives back-to-back blocks, each separated by SETUP plus the DONE/IDLE gap).
- Latency: capture at edge 0 -> SETUP occupies edges 1..R -> first valid y/out_en appears after edge R+1 -> last bit after edge R+K+4.
- Widths: idx, rem and the bit counter are clog2(K+4)+1 bits. C is 8 bits (max 186). R is clog2(K+4)+1 bits.
- Reset asserted mid-block: immediately abort, out_en=0, back to IDLE.
- Degenerate case C >= K+4: R=1, L=K+4, output order equals input order.

Decomposition:
- Shared package: SYM_PER_SLOT=6, a state enum (IDLE, SETUP, OUTPUT, DONE), and a clog2-based width constant function.
- One natural sub-module: nbiot_intlv_addr_gen. It holds the column/row counters, idx, and the L/R-based column-length select. It takes C, R and L; it outputs idx, valid and last.
- The top level keeps the data register, the setup divider, the FSM and the output register.

Test Plan:
- K=2560, n_slots=16 -> C=96, R=27, L=68.
  - Stream is a[0],a[96],...,a[2496] (27 bits), then a[1],...
  - Columns 68..95 carry 26 bits each.
  - Total 2564 out_en cycles.
- K=8 (12 bits), n_slots=1 -> C=6, R=2, L=6.
  - Output a0,a6,a1,a7,a2,a8,a3,a9,a4,a10,a5,a11.
  - First out_en 3 cycles after capture.
- K=10 (14 bits), n_slots=1 -> R=3, L=2.
  - Output a0,a6,a12,a1,a7,a13,a2,a8,a3,a9,a4,a10,a5,a11.
- n_slots=0 with K=8 -> identical to the n_slots=1 case.
- in_en held high -> two back-to-back blocks. Each has exactly K+4 out_en cycles; out_en is low during each SETUP and DONE.
- Reset pulse (reset=0) mid-OUTPUT -> out_en=0 and y=0 asynchronously. After release, a fresh block restarts from bit a[0].

Source files
------------

// File: rtl/nbiot_channel_interleaver_pkg.sv
// rtl/nbiot_channel_interleaver_pkg.sv - shared constants, state type and width helper for the NPUSCH interleaver
package nbiot_channel_interleaver_pkg;

  // Data SC-FDMA symbols per slot (7 symbols minus one DMRS symbol).
  localparam int SYM_PER_SLOT = 6;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    OUTPUT,
    DONE
  } state_t;

  // Counter width able to hold any value 0..n (one bit of headroom over clog2).
  function automatic int width_for(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/nbiot_intlv_addr_gen.sv
// rtl/nbiot_intlv_addr_gen.sv - column-major read address generator for the row-column interleaver
module nbiot_intlv_addr_gen
  import nbiot_channel_interleaver_pkg::*;
#(
  parameter int N  = 2564,
  parameter int IW = width_for(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    c,
  input  logic [IW-1:0] r,
  input  logic [IW-1:0] l,
  output logic [IW-1:0] idx,
  output logic          valid,
  output logic          last
);

  localparam int CW = (IW > 8) ? IW : 8;

  logic [7:0]    col;
  logic [IW-1:0] row;
  logic [IW-1:0] cnt;
  logic [IW-1:0] col_len;
  logic          col_end;

  // Columns left of L hold a full R bits; the rest stop one row short.
  assign col_len = (CW'(col) < CW'(l)) ? r : (r - IW'(1));
  assign col_end = (row == (col_len - IW'(1)));
  // The bit counter, not the column index, decides the end of the block so
  // that empty trailing columns (R=1, L<C) are never visited.
  assign last    = valid && (cnt == IW'(N - 1));

  // Walk rows down a column by adding C, then jump to the top of the next column.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col   <= '0;
      row   <= '0;
      idx   <= '0;
      cnt   <= '0;
      valid <= 1'b0;
    end else if (start) begin
      col   <= '0;
      row   <= '0;
      idx   <= '0;
      cnt   <= '0;
      valid <= 1'b1;
    end else if (valid) begin
      cnt <= cnt + IW'(1);
      if (last) begin
        valid <= 1'b0;
      end
      if (col_end) begin
        col <= col + 8'd1;
        row <= '0;
        idx <= IW'(col) + IW'(1);
      end else begin
        row <= row + IW'(1);
        idx <= idx + IW'(c);
      end
    end
  end

endmodule

// File: rtl/nbiot_channel_interleaver.sv
// rtl/nbiot_channel_interleaver.sv - NB-IoT NPUSCH row-column channel interleaver, parallel in, serial out
module nbiot_channel_interleaver
  import nbiot_channel_interleaver_pkg::*;
#(
  parameter int K = 2560
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [4:0]   n_slots,
  input  logic         in_en,
  input  logic [0:K+3] a,
  output logic         y,
  output logic         out_en
);

  localparam int N  = K + 4;
  localparam int IW = width_for(N);
  localparam int AW = $clog2(N);
  localparam int CW = (IW > 8) ? IW : 8;

  state_t        state;
  state_t        state_next;
  logic [0:N-1]  a_reg;
  logic [7:0]    c_reg;
  logic [IW-1:0] rem;
  logic [IW-1:0] r_cnt;
  logic [IW-1:0] l_reg;
  logic [4:0]    ns_eff;
  logic          rem_gt_c;
  logic          setup_done;
  logic [IW-1:0] idx;
  logic          valid;
  logic          last;

  assign ns_eff     = (n_slots == 5'd0) ? 5'd1 : n_slots;
  assign rem_gt_c   = CW'(rem) > CW'(c_reg);
  assign setup_done = (state == SETUP) && !rem_gt_c;

  nbiot_intlv_addr_gen #(
    .N  (N),
    .IW (IW)
  ) u_addr_gen (
    .clk   (clk),
    .reset (reset),
    .start (setup_done),
    .c     (c_reg),
    .r     (r_cnt),
    .l     (l_reg),
    .idx   (idx),
    .valid (valid),
    .last  (last)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: capture, divide, stream, one idle cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_en) state_next = SETUP;
      SETUP:   if (!rem_gt_c) state_next = OUTPUT;
      OUTPUT:  if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Block capture and repeated-subtraction division giving R rows and L last-row columns.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg <= '0;
      c_reg <= '0;
      rem   <= '0;
      r_cnt <= '0;
      l_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_en) begin
            a_reg <= a;
            c_reg <= 8'(ns_eff) * 8'(SYM_PER_SLOT);
            rem   <= IW'(N);
            r_cnt <= '0;
          end
        end
        SETUP: begin
          r_cnt <= r_cnt + IW'(1);
          if (rem_gt_c) begin
            rem <= IW'(CW'(rem) - CW'(c_reg));
          end else begin
            l_reg <= rem;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Registered serial output; forced low outside the streaming phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y      <= 1'b0;
      out_en <= 1'b0;
    end else begin
      out_en <= (state == OUTPUT) && valid;
      y      <= ((state == OUTPUT) && valid && (idx < IW'(N))) ? a_reg[idx[AW-1:0]] : 1'b0;
    end
  end

endmodule

// File: tb/tb_nbiot_channel_interleaver.sv
// tb/tb_nbiot_channel_interleaver.sv - randomized self-checking bench for nbiot_channel_interleaver
module tb_nbiot_channel_interleaver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [4:0]   n_slots;
  logic         in_en0, in_en1, in_en2;
  logic [0:2563] a_big;
  logic [0:11]  a8;
  logic [0:13]  a10;
  logic         y0, y1, y2, oe0, oe1, oe2;

  int   sel;
  logic y_s, oe_s;
  int   total = 0;
  int   bad = 0;
  bit   exp_bits[$];
  bit   got_q[$];
  int   exp_r;

  nbiot_channel_interleaver #(.K(2560)) u_big (
    .clk(clk), .reset(reset), .n_slots(n_slots), .in_en(in_en0), .a(a_big), .y(y0), .out_en(oe0));
  nbiot_channel_interleaver #(.K(8)) u_k8 (
    .clk(clk), .reset(reset), .n_slots(n_slots), .in_en(in_en1), .a(a8), .y(y1), .out_en(oe1));
  nbiot_channel_interleaver #(.K(10)) u_k10 (
    .clk(clk), .reset(reset), .n_slots(n_slots), .in_en(in_en2), .a(a10), .y(y2), .out_en(oe2));

  always_comb begin
    y_s  = y0;
    oe_s = oe0;
    case (sel)
      1:       begin y_s = y1; oe_s = oe1; end
      2:       begin y_s = y2; oe_s = oe2; end
      default: begin y_s = y0; oe_s = oe0; end
    endcase
  end

  function automatic int n_of(input int dut);
    if (dut == 0) return 2564;
    if (dut == 1) return 12;
    return 14;
  endfunction

  function automatic bit src_bit(input int dut, input int i);
    if (dut == 0) return a_big[i];
    if (dut == 1) return a8[i];
    return a10[i];
  endfunction

  task automatic randomize_a(input int dut);
    for (int i = 0; i < n_of(dut); i++) begin
      if (dut == 0) a_big[i] = 1'($urandom);
      else if (dut == 1) a8[i] = 1'($urandom);
      else a10[i] = 1'($urandom);
    end
  endtask

  task automatic set_en(input int dut, input logic v);
    if (dut == 0) in_en0 = v;
    else if (dut == 1) in_en1 = v;
    else in_en2 = v;
  endtask

  // Reference: bit i sits at row i/C, column i%C; read columns left to right, rows top to bottom.
  task automatic build_model(input int dut, input int ns);
    int n, c;
    n = n_of(dut);
    c = 6 * ((ns == 0) ? 1 : ns);
    exp_r = (n + c - 1) / c;
    exp_bits.delete();
    for (int col = 0; col < c; col++)
      for (int row = 0; row < exp_r; row++)
        if (row * c + col < n) exp_bits.push_back(src_bit(dut, row * c + col));
  endtask

  // Starts one block at the next edge, then scrambles inputs and collects the out_en run.
  task automatic run_stream(input int dut, input int max_cyc, output int first_lat, output bit timed_out);
    got_q.delete();
    first_lat = -1;
    timed_out = 1'b1;
    sel = dut;
    set_en(dut, 1'b1);
    @(posedge clk); #1;
    set_en(dut, 1'b0);
    randomize_a(dut);
    n_slots = 5'($urandom);
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      @(posedge clk); #1;
      if (oe_s) begin
        if (first_lat < 0) first_lat = cyc;
        got_q.push_back(y_s);
      end else if (first_lat >= 0) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    total++; if (oe0 !== 1'b0) begin bad++; $display("FAIL reset_oe0 got=%b want=0", oe0); end
    total++; if (y0 !== 1'b0) begin bad++; $display("FAIL reset_y0 got=%b want=0", y0); end
    total++; if (oe1 !== 1'b0 || oe2 !== 1'b0) begin bad++; $display("FAIL reset_oe_small got=%b%b want=00", oe1, oe2); end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (oe0 !== 1'b0 || y0 !== 1'b0) begin bad++; $display("FAIL idle_quiet got=%b%b want=00", oe0, y0); end
  endtask

  task automatic test_full_size();
    int ns_tbl[4];
    int lat, errs;
    bit to;
    ns_tbl = '{16, 0, 31, 1};
    ns_tbl[1] = $urandom_range(2, 30);
    foreach (ns_tbl[t]) begin
      n_slots = 5'(ns_tbl[t]);
      randomize_a(0);
      build_model(0, ns_tbl[t]);
      run_stream(0, 3500, lat, to);
      total++; if (to) begin bad++; $display("FAIL big_timeout ns=%0d got=timeout want=end", ns_tbl[t]); end
      total++; if (got_q.size() != 2564) begin bad++; $display("FAIL big_count ns=%0d got=%0d want=2564", ns_tbl[t], got_q.size()); end
      total++; if (lat != exp_r + 1) begin bad++; $display("FAIL big_latency ns=%0d got=%0d want=%0d", ns_tbl[t], lat, exp_r + 1); end
      errs = 0;
      for (int i = 0; i < got_q.size() && i < exp_bits.size(); i++) if (got_q[i] != exp_bits[i]) errs++;
      total++; if (errs != 0) begin bad++; $display("FAIL big_bits ns=%0d got=%0d wrong bits want=0", ns_tbl[t], errs); end
    end
  endtask

  task automatic test_small_blocks();
    int tbl_dut[6];
    int tbl_ns[6];
    int lat, errs, ns;
    bit to;
    tbl_dut = '{1, 2, 1, 1, 1, 2};
    tbl_ns  = '{1, 1, 0, 2, 3, 0};
    foreach (tbl_dut[t]) begin
      ns = (t == 5) ? $urandom_range(0, 31) : tbl_ns[t];
      n_slots = 5'(ns);
      randomize_a(tbl_dut[t]);
      build_model(tbl_dut[t], ns);
      run_stream(tbl_dut[t], 100, lat, to);
      total++; if (to) begin bad++; $display("FAIL small_timeout dut=%0d ns=%0d got=timeout want=end", tbl_dut[t], ns); end
      total++; if (got_q.size() != n_of(tbl_dut[t])) begin bad++; $display("FAIL small_count dut=%0d ns=%0d got=%0d want=%0d", tbl_dut[t], ns, got_q.size(), n_of(tbl_dut[t])); end
      total++; if (lat != exp_r + 1) begin bad++; $display("FAIL small_latency dut=%0d ns=%0d got=%0d want=%0d", tbl_dut[t], ns, lat, exp_r + 1); end
      errs = 0;
      for (int i = 0; i < got_q.size() && i < exp_bits.size(); i++) if (got_q[i] != exp_bits[i]) errs++;
      total++; if (errs != 0) begin bad++; $display("FAIL small_bits dut=%0d ns=%0d got=%0d wrong bits want=0", tbl_dut[t], ns, errs); end
    end
  endtask

  task automatic test_back_to_back();
    bit oe_h[$];
    bit y_h[$];
    int starts[$];
    int lens[$];
    int errs;
    n_slots = 5'd1;
    randomize_a(1);
    build_model(1, 1);
    sel = 1;
    set_en(1, 1'b1);
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      oe_h.push_back(oe_s);
      y_h.push_back(y_s);
      if (cyc == 20) set_en(1, 1'b0);
    end
    for (int i = 0; i < oe_h.size(); i++) begin
      if (oe_h[i] && (i == 0 || !oe_h[i-1])) begin starts.push_back(i + 1); lens.push_back(0); end
      if (oe_h[i]) lens[lens.size() - 1]++;
    end
    total++; if (starts.size() != 2) begin bad++; $display("FAIL b2b_runs got=%0d want=2", starts.size()); end
    if (starts.size() == 2) begin
      total++; if (starts[0] != exp_r + 1) begin bad++; $display("FAIL b2b_first got=%0d want=%0d", starts[0], exp_r + 1); end
      total++; if (lens[0] != 12 || lens[1] != 12) begin bad++; $display("FAIL b2b_len got=%0d,%0d want=12,12", lens[0], lens[1]); end
      total++; if (starts[1] - (starts[0] + lens[0]) != exp_r + 2) begin bad++; $display("FAIL b2b_gap got=%0d want=%0d", starts[1] - (starts[0] + lens[0]), exp_r + 2); end
      errs = 0;
      for (int r = 0; r < 2; r++)
        for (int i = 0; i < 12 && i < lens[r]; i++)
          if (y_h[starts[r] - 1 + i] != exp_bits[i]) errs++;
      total++; if (errs != 0) begin bad++; $display("FAIL b2b_bits got=%0d wrong bits want=0", errs); end
    end
  endtask

  task automatic test_reset_mid_block();
    int lat, errs, waited;
    bit to;
    bit first_bit;
    n_slots = 5'd16;
    randomize_a(0);
    sel = 0;
    set_en(0, 1'b1);
    @(posedge clk); #1;
    set_en(0, 1'b0);
    waited = 0;
    while (!oe0 && waited < 200) begin @(posedge clk); #1; waited++; end
    total++; if (oe0 !== 1'b1) begin bad++; $display("FAIL mid_started got=%b want=1", oe0); end
    repeat ($urandom_range(5, 300)) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    total++; if (oe0 !== 1'b0 || y0 !== 1'b0) begin bad++; $display("FAIL mid_async got=%b%b want=00", oe0, y0); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    total++; if (oe0 !== 1'b0) begin bad++; $display("FAIL mid_held got=%b want=0", oe0); end
    n_slots = 5'd16;
    randomize_a(0);
    first_bit = a_big[0];
    build_model(0, 16);
    run_stream(0, 3500, lat, to);
    total++; if (to || got_q.size() != 2564) begin bad++; $display("FAIL mid_restart_count got=%0d want=2564", got_q.size()); end
    if (got_q.size() > 0) begin
      total++; if (got_q[0] != first_bit) begin bad++; $display("FAIL mid_first_bit got=%b want=%b", got_q[0], first_bit); end
    end
    errs = 0;
    for (int i = 0; i < got_q.size() && i < exp_bits.size(); i++) if (got_q[i] != exp_bits[i]) errs++;
    total++; if (errs != 0) begin bad++; $display("FAIL mid_restart_bits got=%0d wrong bits want=0", errs); end
  endtask

  initial begin
    reset   = 1'b0;
    n_slots = 5'd0;
    in_en0  = 1'b0;
    in_en1  = 1'b0;
    in_en2  = 1'b0;
    sel     = 0;
    a_big   = '0;
    a8      = '0;
    a10     = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_small_blocks();
    test_back_to_back();
    repeat (5) @(posedge clk);
    #1;
    test_full_size();
    test_reset_mid_block();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
